// File: rtl/sobel_stream_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sobel_stream_engine_if                                        |
// | Purpose  : Pixel stream bundle between the image source, the Sobel       |
// |            engine and the VGA output registers.                          |
// | Ports    : pix_valid/pix_data/sof  - input stream (source -> engine)     |
// |            out_valid/out_data/out_sof/out_eol/out_eof                    |
// |                                    - output stream (engine -> sink)      |
// |            master modport = source/sink side, slave modport = engine.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface sobel_stream_engine_if #(
  parameter int PIX_W = 8
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             sof;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;

  modport master (
    output pix_valid, pix_data, sof,
    input  out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport slave (
    input  pix_valid, pix_data, sof,
    output out_valid, out_data, out_sof, out_eol, out_eof
  );
endinterface
`default_nettype wire

// File: rtl/sobel_stream_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sobel_stream_engine                                           |
// | Purpose  : Streaming 3x3 Sobel filter. Tracks frame position itself,     |
// |            keeps two line buffers, emits one pixel per accepted input    |
// |            pixel exactly 4 cycles later in one of four modes.            |
// | Ports    : clk_50MHz, rst     - pixel clock, sync active-high reset      |
// |            stream (slave)     - input pixels / output pixels + framing   |
// |            mode, threshold    - sampled at start of frame                |
// |            frame_err          - one-cycle framing error pulse            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sobel_stream_engine #(
  parameter int IMG_WIDTH  = 960,
  parameter int IMG_HEIGHT = 720,
  parameter int PIX_W      = 8
) (
  input  logic                 clk_50MHz,
  input  logic                 rst,
  sobel_stream_engine_if.slave stream,
  input  logic [1:0]           mode,
  input  logic [PIX_W-1:0]     threshold,
  output logic                 frame_err
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int SW = PIX_W + 3;  // signed gradient width
  localparam int MW = PIX_W + 4;  // unsigned magnitude width
  localparam logic [XW-1:0]    c_X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]    c_Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [PIX_W-1:0] c_PIX_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [XW-1:0]    r_x, w_x_nxt, w_px;
  logic [YW-1:0]    r_y, w_y_nxt, w_py;
  logic             w_accept, w_err;
  logic [1:0]       r_mode;
  logic [PIX_W-1:0] r_thr;

  // ---------------- framing FSM ----------------
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_mode    <= 2'd0;
      r_thr     <= '0;
      frame_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      frame_err <= w_err;
      if (w_accept && stream.sof) begin
        r_mode <= mode;
        r_thr  <= threshold;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_px        = r_x;
    w_py        = r_y;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    if (stream.pix_valid) begin
      if (stream.sof) begin
        // sof restarts from any state; only an interrupted frame is an error
        w_accept = 1'b1;
        w_px     = '0;
        w_py     = '0;
        w_err    = (r_state == S_ACTIVE) && ((r_x != '0) || (r_y != '0));
      end else if (r_state == S_ACTIVE) begin
        w_accept = 1'b1;
      end else if (r_state == S_DONE) begin
        w_err = 1'b1;
      end
    end
    if (w_accept) begin
      w_state_nxt = S_ACTIVE;
      if (w_px == c_X_LAST) begin
        w_x_nxt = '0;
        if (w_py == c_Y_LAST) begin
          w_y_nxt     = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_y_nxt = w_py + YW'(1);
        end
      end else begin
        w_x_nxt = w_px + XW'(1);
        w_y_nxt = w_py;
      end
    end
  end

  // ---------------- stage 1: line buffers ----------------
  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];  // row y-1
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];  // row y-2
  logic             r_s1_valid, r_s2_valid, r_s3_valid;
  logic [PIX_W-1:0] r_s1_top, r_s1_mid, r_s1_bot;
  logic [3:0]       r_s1_flg, r_s2_flg, r_s3_flg;  // {border, sof, eol, eof}
  logic [1:0]       r_s1_mode, r_s2_mode, r_s3_mode;
  logic [PIX_W-1:0] r_s1_thr, r_s2_thr, r_s3_thr;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Read-before-write: the column shifts down one row per accepted pixel.
  always_ff @(posedge clk_50MHz) begin
    if (w_accept) begin
      r_s1_top    <= r_lb1[w_px];
      r_s1_mid    <= r_lb0[w_px];
      r_s1_bot    <= stream.pix_data;
      r_lb0[w_px] <= stream.pix_data;
      r_lb1[w_px] <= r_lb0[w_px];
      r_s1_flg    <= {(w_px < XW'(2)) || (w_py < YW'(2)),
                      (w_px == '0) && (w_py == '0),
                      (w_px == c_X_LAST),
                      (w_px == c_X_LAST) && (w_py == c_Y_LAST)};
      // the frame's first pixel already sees the newly latched settings
      r_s1_mode   <= stream.sof ? mode : r_mode;
      r_s1_thr    <= stream.sof ? threshold : r_thr;
    end
  end

  // ---------------- stage 2: 3x3 window ----------------
  logic [PIX_W-1:0] r_win [3][3];  // [row][col], col 2 = newest column

  always_ff @(posedge clk_50MHz) begin
    if (r_s1_valid) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= r_s1_top;
      r_win[1][2] <= r_s1_mid;
      r_win[2][2] <= r_s1_bot;
      r_s2_flg    <= r_s1_flg;
      r_s2_mode   <= r_s1_mode;
      r_s2_thr    <= r_s1_thr;
    end
  end

  // ---------------- stage 3: gradient magnitude ----------------
  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [SW-1:0] w_gx, w_gy;
  logic [SW-1:0]        w_gx_abs, w_gy_abs;
  logic [MW-1:0]        w_mag, r_s3_mag;
  logic [PIX_W-1:0]     r_s3_p11;

  always_comb begin
    w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
         - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
    w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
         - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));
    w_gx_abs = w_gx[SW-1] ? -w_gx : w_gx;
    w_gy_abs = w_gy[SW-1] ? -w_gy : w_gy;
    w_mag    = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};
  end

  always_ff @(posedge clk_50MHz) begin
    if (r_s2_valid) begin
      r_s3_mag  <= w_mag;
      r_s3_p11  <= r_win[1][1];
      r_s3_flg  <= r_s2_flg;
      r_s3_mode <= r_s2_mode;
      r_s3_thr  <= r_s2_thr;
    end
  end

  // ---------------- stage 4: mode select / output ----------------
  logic             w_bin;
  logic [PIX_W-1:0] w_sat, w_result;
  logic             r_out_valid, r_out_sof, r_out_eol, r_out_eof;
  logic [PIX_W-1:0] r_out_data;

  always_comb begin
    w_result = '0;
    w_bin    = (r_s3_mag > {4'b0000, r_s3_thr});
    w_sat    = (r_s3_mag > {4'b0000, c_PIX_MAX}) ? c_PIX_MAX : r_s3_mag[PIX_W-1:0];
    case (r_s3_mode)
      2'd0:    w_result = r_s3_p11;
      2'd1:    w_result = w_sat;
      2'd2:    w_result = w_bin ? c_PIX_MAX : '0;
      default: w_result = w_bin ? '0 : c_PIX_MAX;
    endcase
    // the first two rows/columns have no complete window
    if (r_s3_flg[3]) w_result = '0;
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      r_out_valid <= r_s3_valid;
      r_out_data  <= r_s3_valid ? w_result : '0;
      r_out_sof   <= r_s3_valid & r_s3_flg[2];
      r_out_eol   <= r_s3_valid & r_s3_flg[1];
      r_out_eof   <= r_s3_valid & r_s3_flg[0];
    end
  end

  assign stream.out_valid = r_out_valid;
  assign stream.out_data  = r_out_data;
  assign stream.out_sof   = r_out_sof;
  assign stream.out_eol   = r_out_eol;
  assign stream.out_eof   = r_out_eof;

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sobel_stream_engine                                        |
// | Purpose  : Directed self-checking bench for sobel_stream_engine on an    |
// |            8x6 image: reset, all four modes, framing errors, gaps.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sobel_stream_engine;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk_50MHz = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic       frame_err;

  sobel_stream_engine_if #(.PIX_W(8)) s ();

  sobel_stream_engine #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .stream    (s),
    .mode      (mode),
    .threshold (threshold),
    .frame_err (frame_err)
  );

  initial forever #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [7:0] data;
    logic [2:0] flags;  // {sof, eol, eof}
    int         cyc;
    int         x;
    int         y;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   eof_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   img [H][W];
  int   obs_img [H][W];
  int   last_sof_cyc;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  always @(negedge clk_50MHz) begin
    if (s.out_valid) begin
      ent_t o;
      o.data  = s.out_data;
      o.flags = {s.out_sof, s.out_eol, s.out_eof};
      o.cyc   = cyc;
      o.x     = 0;
      o.y     = 0;
      obs_q.push_back(o);
      if (s.out_eof) eof_cnt++;
    end
    if (frame_err) err_q.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference Sobel computed straight from the stored image.
  function automatic logic [7:0] exp_pix(input logic [1:0] m, input logic [7:0] t,
                                         input int x, input int y);
    int p [3][3];
    int gx, gy, mag;
    if (x < 2 || y < 2) return 8'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = img[y-2+r][x-2+c];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    case (m)
      2'd0:    return 8'(img[y-1][x-1]);
      2'd1:    return (mag > 255) ? 8'd255 : 8'(mag);
      2'd2:    return (mag > int'(t)) ? 8'd255 : 8'd0;
      default: return (mag > int'(t)) ? 8'd0 : 8'd255;
    endcase
  endfunction

  task automatic fill_ramp();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8*y + x;
  endtask

  task automatic fill_step(input int v);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x >= 4) ? v : 0;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = int'($urandom_range(255, 0));
  endtask

  // Drives n pixels of img starting at (0,0) with sof; gap_pct % idle cycles.
  // At pixel chg_at the mode/threshold inputs switch to new_m/new_t.
  task automatic send_frame(input int n, input int gap_pct, input bit record,
                            input logic [1:0] em, input logic [7:0] et,
                            input int chg_at, input logic [1:0] new_m, input logic [7:0] new_t);
    for (int i = 0; i < n; i++) begin
      int x, y;
      while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        s.pix_valid = 1'b0;
        s.sof       = 1'($urandom_range(1, 0));
        s.pix_data  = 8'($urandom_range(255, 0));
        tick();
      end
      if (i == chg_at) begin
        mode      = new_m;
        threshold = new_t;
      end
      x = i % W;
      y = i / W;
      s.pix_valid = 1'b1;
      s.sof       = (i == 0);
      s.pix_data  = 8'(img[y][x]);
      if (i == 0) last_sof_cyc = cyc;
      if (record) begin
        ent_t e;
        e.data  = exp_pix(em, et, x, y);
        e.flags = {i == 0, x == W-1, (x == W-1) && (y == H-1)};
        e.cyc   = cyc;
        e.x     = x;
        e.y     = y;
        exp_q.push_back(e);
      end
      tick();
    end
    s.pix_valid = 1'b0;
    s.sof       = 1'b0;
  endtask

  task automatic send_nosof(input int n);
    for (int i = 0; i < n; i++) begin
      s.pix_valid = 1'b1;
      s.sof       = 1'b0;
      s.pix_data  = 8'(i * 37);
      tick();
    end
    s.pix_valid = 1'b0;
  endtask

  task automatic check_frames();
    repeat (8) tick();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) obs_img[y][x] = -1;
    chk("out_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("data(%0d,%0d)", e.x, e.y), o.data, e.data);
      chk($sformatf("flags(%0d,%0d)", e.x, e.y), o.flags, e.flags);
      chk($sformatf("latency(%0d,%0d)", e.x, e.y), o.cyc - e.cyc, 4);
      obs_img[e.y][e.x] = o.data;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int done_cyc;
    rst         = 1'b1;
    mode        = 2'd0;
    threshold   = 8'd0;
    s.pix_valid = 1'b0;
    s.sof       = 1'b0;
    s.pix_data  = 8'd0;
    repeat (3) tick();

    // reset state
    chk("rst_out_valid", s.out_valid, 0);
    chk("rst_out_data",  s.out_data, 0);
    chk("rst_out_flags", {s.out_sof, s.out_eol, s.out_eof}, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    tick();

    // pixels without sof in IDLE: dropped, no error
    send_nosof(3);
    repeat (6) tick();
    chk("idle_drop_out", obs_q.size(), 0);
    chk("idle_drop_err", err_q.size(), 0);

    // reset mid-stream with pix_valid high
    fill_ramp();
    send_frame(10, 0, 1'b0, 2'd0, 8'd0, -1, 2'd0, 8'd0);
    s.pix_valid = 1'b1;
    s.pix_data  = 8'd99;
    rst         = 1'b1;
    tick();
    chk("midrst_out_valid", s.out_valid, 0);
    chk("midrst_out_data",  s.out_data, 0);
    chk("midrst_out_flags", {s.out_sof, s.out_eol, s.out_eof}, 0);
    chk("midrst_frame_err", frame_err, 0);
    obs_q.delete();
    err_q.delete();
    tick();
    rst = 1'b0;
    send_nosof(6);
    repeat (8) tick();
    chk("postrst_drop_out", obs_q.size(), 0);
    chk("postrst_drop_err", err_q.size(), 0);

    // mode 0 passthrough, ramp, continuous
    eof_cnt = 0;
    mode = 2'd0; threshold = 8'd0;
    send_frame(W*H, 0, 1'b1, 2'd0, 8'd0, -1, 2'd0, 8'd0);
    check_frames();
    chk("ramp_p(7,5)", obs_img[5][7], 38);
    chk("ramp_p(2,2)", obs_img[2][2], 9);
    chk("ramp_p(1,3)", obs_img[3][1], 0);
    chk("ramp_eof_count", eof_cnt, 1);

    // mode 1 magnitude, step 0 -> 200 (mag 800 saturates)
    fill_step(200);
    mode = 2'd1;
    send_frame(W*H, 0, 1'b1, 2'd1, 8'd0, -1, 2'd0, 8'd0);
    check_frames();
    chk("mag_p(4,2)", obs_img[2][4], 255);
    chk("mag_p(5,5)", obs_img[5][5], 255);
    chk("mag_p(6,3)", obs_img[3][6], 0);
    chk("mag_p(3,4)", obs_img[4][3], 0);

    // mode 2 binary, step 0 -> 20 (mag 80), threshold 79 then 80
    fill_step(20);
    mode = 2'd2; threshold = 8'd79;
    send_frame(W*H, 0, 1'b1, 2'd2, 8'd79, -1, 2'd0, 8'd0);
    check_frames();
    chk("bin79_p(4,2)", obs_img[2][4], 255);
    chk("bin79_p(5,4)", obs_img[4][5], 255);
    chk("bin79_p(3,3)", obs_img[3][3], 0);
    threshold = 8'd80;
    send_frame(W*H, 0, 1'b1, 2'd2, 8'd80, -1, 2'd0, 8'd0);
    check_frames();
    chk("bin80_p(4,2)", obs_img[2][4], 0);
    chk("bin80_p(5,5)", obs_img[5][5], 0);

    // mode 3 inverted binary, threshold 79
    mode = 2'd3; threshold = 8'd79;
    send_frame(W*H, 0, 1'b1, 2'd3, 8'd79, -1, 2'd0, 8'd0);
    check_frames();
    chk("inv_p(4,2)", obs_img[2][4], 0);
    chk("inv_p(2,3)", obs_img[3][2], 255);
    chk("inv_p(6,3)", obs_img[3][6], 255);
    chk("inv_p(5,0)", obs_img[0][5], 0);
    chk("inv_p(1,4)", obs_img[4][1], 0);

    // short frame (20 pixels) then restart, then extra pixels after DONE
    fill_ramp();
    mode = 2'd0; threshold = 8'd0;
    err_q.delete();
    send_frame(20, 0, 1'b1, 2'd0, 8'd0, -1, 2'd0, 8'd0);
    send_frame(W*H, 0, 1'b1, 2'd0, 8'd0, -1, 2'd0, 8'd0);
    done_cyc = cyc;
    send_nosof(3);
    check_frames();
    chk("short_err_count", err_q.size(), 4);
    if (err_q.size() == 4) begin
      chk("short_err_cycle", err_q[0], last_sof_cyc + 1);
      chk("done_err0_cycle", err_q[1], done_cyc + 1);
      chk("done_err2_cycle", err_q[3], done_cyc + 3);
    end
    chk("short_restart_p(7,5)", obs_img[5][7], 38);

    // random gaps, two back-to-back frames, mode changed mid first frame
    err_q.delete();
    eof_cnt = 0;
    fill_rand();
    mode = 2'd1; threshold = 8'd50;
    send_frame(W*H, 50, 1'b1, 2'd1, 8'd50, 24, 2'd2, 8'd100);
    fill_rand();
    send_frame(W*H, 50, 1'b1, 2'd2, 8'd100, -1, 2'd0, 8'd0);
    check_frames();
    chk("gap_err_count", err_q.size(), 0);
    chk("gap_eof_count", eof_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_stream_engine.md
# sobel_stream_engine

Parametrised streaming Sobel engine for the VGA edge-detection datapath: consumes one grey pixel per valid cycle in raster order, builds a 3x3 window from two internal line buffers, and emits a pixel per input pixel at a fixed latency in one of four frame-selectable modes. It sits between the image source (ROM or camera) and the VGA output registers, and replaces position-driven filtering with self-tracked frame framing and error reporting.

## Interface
- IMG_WIDTH, 960, pixels per line (>=3)
- IMG_HEIGHT, 720, lines per frame (>=3)
- PIX_W, 8, pixel bit width
- clk_50MHz  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  PIX_W  input grey pixel
- sof  in  1  start of frame; qualifies pixel (0,0) only together with pix_valid
- mode  in  2  0 passthrough, 1 magnitude, 2 binary, 3 inverted binary
- threshold  in  PIX_W  binary-mode threshold
- out_valid  out  1  output pixel valid
- out_data  out  PIX_W  output pixel
- out_sof  out  1  first output pixel of frame
- out_eol  out  1  last output pixel of a line
- out_eof  out  1  last output pixel of frame
- frame_err  out  1  one-cycle framing error pulse

## Operation
- FSM: IDLE (wait for sof), ACTIVE (counting x,y), DONE (full frame received, wait for sof).
- sof&pix_valid in any state: x=y=0, pixel accepted, mode/threshold latched, state ACTIVE. In ACTIVE with count nonzero: frame_err pulse (short frame), restart.
- sof without pix_valid: ignored.
- pix_valid without sof: IDLE -> dropped silently; ACTIVE -> accepted; DONE -> dropped, frame_err pulse per dropped pixel.
- Counters: x wraps at IMG_WIDTH-1, y increments; pixel (IMG_WIDTH-1, IMG_HEIGHT-1) -> DONE.
- Line buffers lb0 (row y-1), lb1 (row y-2), depth IMG_WIDTH: on accepted pixel at x read lb0[x], lb1[x]; write lb0[x]=pix, lb1[x]=old lb0[x]. Not cleared on sof or reset.
- Window pRC: row 0 = y-2, column 0 = x-2; center p11 = pixel (x-1,y-1).
- Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02); signed PIX_W+3 bits, no overflow.
- mag = |Gx|+|Gy|, PIX_W+4 bits unsigned; sat = min(mag, 2^PIX_W-1).
- Output for input (x,y): if x<2 or y<2 -> 0 (all modes); else mode 0 p11, mode 1 sat, mode 2 (mag>threshold ? all-ones : 0), mode 3 its complement. Comparison strict, full-width mag.
- Output image equals input geometry, shifted by (1,1); row 0/1, column 0/1 zero.
- mode/threshold changes mid-frame take effect only at next sof.

## Timing
- Fixed latency 4: out_valid asserted exactly 4 cycles after each accepted pix_valid; dropped pixels produce no output.
- Gaps in pix_valid allowed anywhere; no back-pressure; pix_valid every cycle sustained.
- out_sof/out_eol/out_eof aligned with the out_valid of pixels (0,0), (IMG_WIDTH-1,y), (IMG_WIDTH-1,IMG_HEIGHT-1).
- frame_err asserted the cycle after the offending input, one cycle.
- Reset: all outputs 0 next edge, FSM IDLE, x=y=0, latched mode 0, threshold 0, pipeline valids cleared; in-flight pixels discarded; reset mid-frame needs new sof.
- Short frame: pixels already in the pipeline still emerge; new frame's out_sof follows 4 cycles after the restart pixel.

## Test plan
Parameters IMG_WIDTH=8, IMG_HEIGHT=6, PIX_W=8.
- Reset mid-stream with pix_valid high -> out_valid=0, all outputs 0 from next cycle; pixels without sof dropped, no frame_err.
- Mode 0, ramp pix=8y+x, continuous valid -> out_valid 4 cycles after each input; output at (x,y), x,y>=2 equals 8(y-1)+(x-1); else 0; out_eol at x=7, out_eof once.
- Mode 1, columns 0-3=0, 4-7=200 -> rows y>=2: output x=4,5 = 255 (mag 800 saturated), other x = 0.
- Mode 2, columns 0-3=0, 4-7=20 (mag 80): threshold 79 -> x=4,5 = 255; threshold 80 -> all 0; mode 3 same frame inverted.
- sof after 20 pixels -> frame_err pulse once, new frame counts from (0,0), out_sof 4 cycles later; after full frame, extra pix_valid without sof -> frame_err per pixel, no out_valid.
- Random pix_valid gaps (50%) over two back-to-back frames, mode changed mid-frame -> outputs match gap-free reference, new mode applied only from second frame.
